// File: rtl/gf_mul_arbiter.sv
// gf_mul_arbiter: round-robin sharing of one multi-cycle modular multiplier among NREQ requesters, with a watchdog on each operation.
module gf_mul_arbiter #(
   parameter int NREQ = 2,
   parameter int BW_GF = 256,
   parameter int TIMEOUT = 1023,
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int TW = $clog2(TIMEOUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid_i,
   input  logic [NREQ*BW_GF-1:0] req_a_i,
   input  logic [NREQ*BW_GF-1:0] req_b_i,
   output logic [NREQ-1:0]       req_ready_o,
   output logic [NREQ-1:0]       rsp_valid_o,
   output logic                  rsp_err_o,
   output logic [BW_GF-1:0]      rsp_data_o,
   output logic                  mul_start_o,
   output logic [BW_GF-1:0]      mul_a_o,
   output logic [BW_GF-1:0]      mul_b_o,
   input  logic [BW_GF-1:0]      mul_out_i,
   input  logic                  mul_valid_i,
   output logic                  busy_o,
   output logic [IW-1:0]         grant_id_o
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);
   state_e            state_q;
   logic [IW-1:0]     rr_q, grant_q, grant_d, idx;
   logic [TW-1:0]     wdog_q;
   logic [NREQ-1:0]   rsp_valid_q;
   logic              rsp_err_q, mul_start_q, busy_q, hit;
   logic [BW_GF-1:0]  rsp_data_q, mul_a_q, mul_b_q;
   // Scan downward so the requester nearest after rr_q is written last and wins.
   always_comb begin
      grant_d = '0;
      hit = 1'b0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(rr_q) + k) % NREQ);
         if (req_valid_i[idx]) begin
            grant_d = idx;
            hit = 1'b1;
         end
      end
   end
   assign req_ready_o = (rst_n && state_q == S_IDLE && hit) ? ONE << grant_d : '0;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o = rsp_err_q;
   assign rsp_data_o = rsp_data_q;
   assign mul_start_o = mul_start_q;
   assign mul_a_o = mul_a_q;
   assign mul_b_o = mul_b_q;
   assign busy_o = busy_q;
   assign grant_id_o = grant_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rr_q <= IW'(NREQ - 1);
         grant_q <= '0;
         wdog_q <= '0;
         rsp_valid_q <= '0;
         rsp_err_q <= 1'b0;
         rsp_data_q <= '0;
         mul_start_q <= 1'b0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         busy_q <= 1'b0;
      end else begin
         mul_start_q <= 1'b0;
         rsp_valid_q <= '0;
         case (state_q)
            S_IDLE: if (hit) begin
               mul_a_q <= req_a_i[int'(grant_d)*BW_GF +: BW_GF];
               mul_b_q <= req_b_i[int'(grant_d)*BW_GF +: BW_GF];
               grant_q <= grant_d;
               mul_start_q <= 1'b1;
               busy_q <= 1'b1;
               state_q <= S_ISSUE;
            end
            S_ISSUE: begin
               wdog_q <= '0;
               state_q <= S_WAIT;
            end
            // A product arriving on the timeout cycle still counts as a success.
            S_WAIT: if (mul_valid_i) begin
               rsp_data_q <= mul_out_i;
               rsp_err_q <= 1'b0;
               rsp_valid_q <= ONE << grant_q;
               state_q <= S_RESP;
            end else if (wdog_q == TW'(TIMEOUT)) begin
               rsp_data_q <= '0;
               rsp_err_q <= 1'b1;
               rsp_valid_q <= ONE << grant_q;
               state_q <= S_RESP;
            end else begin
               wdog_q <= wdog_q + 1'b1;
            end
            S_RESP: begin
               rr_q <= grant_q;
               busy_q <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gf_mul_arbiter.sv
// tb_gf_mul_arbiter: table-driven, hand-sequenced and randomized checks of the arbiter against a stub multiplier and a transaction-level model.
module tb_gf_mul_arbiter;
   localparam int N = 3;
   localparam int W = 16;
   logic clk = 1'b0, rst_n;
   logic [N-1:0] req_valid, req_ready, rsp_valid;
   logic [N*W-1:0] req_a, req_b;
   logic rsp_err, mul_start, mul_valid, busy;
   logic [W-1:0] rsp_data, mul_a, mul_b, mul_out;
   logic [1:0] grant_id;
   int errors = 0, checks = 0, cyc = 0;
   int lat = 4, cd = 0;
   bit stub_on = 1'b1, stray = 1'b0;
   typedef struct {int idx; logic [W-1:0] a, b; int lat; bit on; logic err; logic [W-1:0] data; int rcyc;} vec_t;
   typedef struct {int cyc; int own; logic [W-1:0] d;} rsp_t;
   vec_t tbl[6];
   rsp_t expq[$];
   gf_mul_arbiter #(.NREQ(N), .BW_GF(W), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
      .mul_start_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_out_i(mul_out),
      .mul_valid_i(mul_valid), .busy_o(busy), .grant_id_o(grant_id)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   // Stub multiplier: answers lat cycles after the start pulse with a*b.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      mul_valid = 1'b0;
      if (cd > 0) begin
         cd--;
         if (cd == 0 && stub_on) begin
            mul_valid = 1'b1;
            mul_out = mul_a * mul_b;
         end
      end
      if (mul_start) cd = lat;
      if (stray) begin
         mul_valid = 1'b1;
         mul_out = 16'hdead;
      end
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = '0;
      tick();
      tick();
      rst_n = 1'b1;
      cd = 0;
   endtask
   function automatic int rr_pick(input logic [N-1:0] v, input int lst);
      for (int k = 1; k <= N; k++) if (v[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction
   task automatic run_txn(input vec_t v);
      bit got;
      lat = v.lat;
      stub_on = v.on;
      req_a = 48'({$urandom, $urandom});
      req_b = 48'({$urandom, $urandom});
      req_a[v.idx*W +: W] = v.a;
      req_b[v.idx*W +: W] = v.b;
      req_valid = 3'b001 << v.idx;
      #1;
      chk("txn_ready", req_ready, 3'b001 << v.idx);
      chk("txn_busy0", busy, 0);
      tick();
      req_valid = '0;
      #1;
      chk("txn_start1", mul_start, 1);
      chk("txn_busy1", busy, 1);
      chk("txn_grant", grant_id, v.idx);
      chk("txn_mul_a", mul_a, v.a);
      chk("txn_mul_b", mul_b, v.b);
      tick();
      #1;
      chk("txn_start2", mul_start, 0);
      got = 1'b0;
      for (int c = 2; c < 40 && !got; c++) begin
         if (c > 2) tick();
         #1;
         if (rsp_valid != '0) begin
            got = 1'b1;
            chk("txn_rsp_cycle", c, v.rcyc);
            chk("txn_rsp_valid", rsp_valid, 3'b001 << v.idx);
            chk("txn_rsp_data", rsp_data, v.data);
            chk("txn_rsp_err", rsp_err, v.err);
         end
      end
      if (!got) chk("txn_rsp_missing", 0, 1);
      tick();
      #1;
      chk("txn_idle_busy", busy, 0);
   endtask
   // Two requesters held valid from reset: owners alternate, accepts 7 cycles apart.
   task automatic contend(input logic [N-1:0] v, input int o0, input int o1);
      int n, prev, own;
      logic [W-1:0] p;
      n = 0;
      prev = 0;
      own = -1;
      lat = 4;
      stub_on = 1'b1;
      req_a = {16'd23, 16'd17, 16'd11};
      req_b = {16'd29, 16'd19, 16'd13};
      req_valid = v;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) tick();
         #1;
         if (req_ready != '0) begin
            own = (n % 2 == 0) ? o0 : o1;
            chk("cont_grant", req_ready, 3'b001 << own);
            if (n > 0) chk("cont_spacing", c - prev, 7);
            prev = c;
            n++;
         end
         if (rsp_valid != '0) begin
            p = req_a[own*W +: W] * req_b[own*W +: W];
            chk("cont_rsp_owner", rsp_valid, 3'b001 << own);
            chk("cont_rsp_data", rsp_data, p);
         end
      end
      chk("cont_accepts", n, 5);
      req_valid = '0;
   endtask
   initial begin
      int g, last, next_free, l;
      logic [N-1:0] expr;
      bit pend[N];
      logic [W-1:0] ra[N], rb[N];
      int gprev;
      tbl[0] = '{0, 16'd3, 16'd5, 4, 1'b1, 1'b0, 16'd15, 6};
      tbl[1] = '{2, 16'h00ff, 16'h0101, 2, 1'b1, 1'b0, 16'hffff, 4};
      tbl[2] = '{1, 16'd300, 16'd300, 1, 1'b1, 1'b0, 16'd24464, 3};
      tbl[3] = '{1, 16'h1234, 16'h5678, 4, 1'b0, 1'b1, 16'd0, 18};
      tbl[4] = '{0, 16'd7, 16'd9, 16, 1'b1, 1'b0, 16'd63, 18};
      tbl[5] = '{2, 16'd1000, 16'd3, 15, 1'b1, 1'b0, 16'd3000, 17};
      rst_n = 1'b0;
      req_valid = 3'b111;
      req_a = '1;
      req_b = '1;
      mul_valid = 1'b0;
      mul_out = '0;
      #2;
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_start", mul_start, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      chk("rst_grant", grant_id, 0);
      do_reset();
      contend(3'b011, 0, 1);
      do_reset();
      contend(3'b101, 0, 2);
      do_reset();
      stray = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         #1;
         chk("stray_rsp", rsp_valid, 0);
         chk("stray_busy", busy, 0);
      end
      stray = 1'b0;
      tick();
      for (int i = 0; i < 6; i++) run_txn(tbl[i]);
      // Reset lands mid-WAIT; the stub's late answer must be ignored afterwards.
      lat = 10;
      stub_on = 1'b1;
      req_valid = 3'b001;
      tick();
      req_valid = '0;
      tick();
      tick();
      tick();
      #2;
      chk("mid_busy_pre", busy, 1);
      rst_n = 1'b0;
      req_valid = 3'b111;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_start", mul_start, 0);
      chk("mid_rsp", rsp_valid, 0);
      chk("mid_ready", req_ready, 0);
      tick();
      tick();
      rst_n = 1'b1;
      req_valid = '0;
      for (int c = 0; c < 10; c++) begin
         tick();
         #1;
         chk("mid_late_rsp", rsp_valid, 0);
         chk("mid_late_busy", busy, 0);
      end
      run_txn(tbl[0]);
      do_reset();
      last = N - 1;
      next_free = cyc;
      gprev = -1;
      expq.delete();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int t = 0; t < 800; t++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (i == gprev) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               ra[i] = W'($urandom);
               rb[i] = W'($urandom);
            end else if (pend[i] && $urandom_range(0, 31) == 0) begin
               pend[i] = 1'b0;
            end
            req_valid[i] = pend[i];
            req_a[i*W +: W] = pend[i] ? ra[i] : W'($urandom);
            req_b[i*W +: W] = pend[i] ? rb[i] : W'($urandom);
         end
         gprev = -1;
         expr = '0;
         if (cyc >= next_free && req_valid != '0) begin
            g = rr_pick(req_valid, last);
            expr = 3'b001 << g;
            l = $urandom_range(1, 6);
            lat = l;
            expq.push_back('{cyc + 2 + l, g, W'(ra[g] * rb[g])});
            next_free = cyc + l + 3;
            last = g;
            gprev = g;
         end
         #1;
         chk("rand_ready", req_ready, expr);
         if (expq.size() > 0 && expq[0].cyc == cyc) begin
            chk("rand_rsp_valid", rsp_valid, 3'b001 << expq[0].own);
            chk("rand_rsp_data", rsp_data, expq[0].d);
            chk("rand_rsp_err", rsp_err, 0);
            void'(expq.pop_front());
         end else begin
            chk("rand_rsp_idle", rsp_valid, 0);
         end
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gf_mul_arbiter.md
Name: gf_mul_arbiter

Overview:
- Round-robin scheduler that shares one multi-cycle modular multiplier (start/valid protocol, result width BW_GF) among NREQ independent requesters, e.g. two point-scalar engines or an ECDSA post-processor.
- Accepts one operand pair per grant, sequences the multiplier, routes the product back to the originating requester, and guards against a hung multiplier with a watchdog.

Parameters:
- NREQ, 2, number of requesters (2..4).
- BW_GF, 256, operand/result width in bits.
- TIMEOUT, 1023, maximum cycles allowed between mul_start and mul_valid before the operation is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  requester i has an operand pair pending.
- req_a  in  NREQ*BW_GF  operand A; requester i occupies bits [i*BW_GF +: BW_GF].
- req_b  in  NREQ*BW_GF  operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  NREQ  one-hot, one-cycle result strobe.
- rsp_err  out  1  qualifies rsp_valid; 1 = watchdog abort.
- rsp_data  out  BW_GF  product; valid while any rsp_valid bit is 1.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_a  out  BW_GF  latched operand A to the multiplier.
- mul_b  out  BW_GF  latched operand B to the multiplier.
- mul_out  in  BW_GF  multiplier product.
- mul_valid  in  1  multiplier result-valid pulse.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NREQ)  index of the current or last owner.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = NREQ-1, grant_id = 0.
  - mul_start, rsp_valid, rsp_err, busy = 0.
  - mul_a, mul_b, rsp_data = 0, wdog = 0.
  - req_ready is forced to 0 while rst_n is low.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first i with req_valid[i] set, searching (rr_ptr+1) mod NREQ upward with wrap.
  - req_ready[i] = 1 combinationally in that same cycle; all other bits are 0.
  - The transfer occurs on that clock edge: latch req_a/req_b slice i into mul_a/mul_b, set grant_id = i, go to ISSUE.
  - No req_valid set: stay in IDLE, req_ready = 0.
- ISSUE: mul_start = 1 for exactly one cycle, wdog cleared, go to WAIT.
- WAIT:
  - mul_valid = 1: latch mul_out into rsp_data, rsp_err = 0, go to RESP.
  - Otherwise increment wdog. When wdog == TIMEOUT: rsp_data = 0, rsp_err = 1, go to RESP.
  - If mul_valid and timeout coincide, mul_valid wins.
- RESP:
  - rsp_valid[grant_id] = 1 for one cycle, rr_ptr = grant_id, go to IDLE.
  - The requester must consume the result in that cycle; there is no backpressure.
- Latency (L = multiplier latency from mul_start to mul_valid):
  - Accept edge at cycle 0, mul_start in cycle 1, mul_valid in cycle 1+L, rsp_valid in cycle 2+L.
  - Minimum spacing between successive accepts is L+3 cycles.
- mul_valid received outside WAIT is ignored; there is no state change and no response.
- req_valid must remain high until req_ready; the block does not sample the operands of a non-granted requester.
- A requester may drop req_valid before it is granted without error; it simply loses its turn.
- Fairness:
  - The last owner has the lowest priority next round.
  - With all requesters continuously valid, each is served once per NREQ operations.
- Reset mid-operation:
  - Asynchronous return to IDLE with all outputs at reset values.
  - The in-flight product is discarded; the owner must re-request.
  - The multiplier is reset separately by its own reset.
- Operands are passed unmodified; modular reduction is the multiplier's responsibility.

Test Plan:
- Single request: req_valid=01, a=3, b=5, stub multiplier with L=4 returning 15 → req_ready=01 at cycle 0, mul_start at cycle 1, rsp_valid=01 and rsp_data=15 at cycle 6, rsp_err=0.
- Contention: req_valid=11 held from reset → grants alternate 0,1,0,1; each rsp_valid goes to the matching owner; rsp_data equals that owner's a*b; accept spacing is 7 cycles with L=4.
- Fairness after wrap: NREQ=3, requesters 0 and 2 continuously valid, last owner 2 → next grant is 0, then 2, and never 1 while req_valid[1]=0.
- Watchdog: stub never asserts mul_valid, TIMEOUT=15 → rsp_valid for the owner with rsp_err=1, rsp_data=0 at cycle 1+16+1; the FSM returns to IDLE and accepts the next request.
- Stray and boundary: mul_valid pulsed while in IDLE → no rsp_valid; mul_valid in the same cycle as the timeout → rsp_err=0 and the product is delivered.
- Reset mid-WAIT: assert rst_n=0 asynchronously between clock edges → busy, mul_start and rsp_valid drop immediately; after release the pending mul_valid is ignored and a fresh request completes normally.
